// File: rtl/daq_read_sequencer.sv
// Read-command sequencer for wb_master_interface: issues base/stride/count single reads
// one at a time and buffers the returned words in a first-word-fall-through FIFO.
module daq_read_sequencer #(
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 cfg_go,
  input  logic                 cfg_abort,
  input  logic [aw-1:0]        cfg_base,
  input  logic [aw-1:0]        cfg_stride,
  input  logic [15:0]          cfg_count,
  input  logic [3:0]           cfg_sel,
  output logic                 start,
  output logic [aw-1:0]        address,
  output logic [3:0]           selection,
  output logic                 write,
  output logic [dw-1:0]        data_wr,
  input  logic [dw-1:0]        data_rd,
  input  logic                 active,
  input  logic                 fifo_rd_en,
  output logic [dw-1:0]        fifo_rd_data,
  output logic                 fifo_empty,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW         = 16;
  localparam int unsigned LW         = FIFO_AW + 1;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_DONE
  } state_t;

  state_t              r_state;
  logic [aw-1:0]       r_addr;
  logic [aw-1:0]       r_stride;
  logic [3:0]          r_sel;
  logic [CW-1:0]       r_remaining;
  logic                r_abort_pend;
  logic                r_start;
  logic [aw-1:0]       r_address;
  logic [3:0]          r_selection;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [aw-1:0]       w_addr_nxt;
  logic [aw-1:0]       w_stride_nxt;
  logic [3:0]          w_sel_nxt;
  logic [CW-1:0]       w_rem_nxt;
  logic                w_abort_nxt;
  logic                w_abort_seen;
  logic                w_start_nxt;
  logic [aw-1:0]       w_address_nxt;
  logic [3:0]          w_selection_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_push;
  logic                w_pop;

  logic [dw-1:0]       r_mem [0:FIFO_DEPTH-1];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_empty;
  logic [LW-1:0]       w_level_nxt;

  // State and registered command outputs
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_stride     <= '0;
      r_sel        <= '0;
      r_remaining  <= '0;
      r_abort_pend <= 1'b0;
      r_start      <= 1'b0;
      r_address    <= '0;
      r_selection  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_stride     <= w_stride_nxt;
      r_sel        <= w_sel_nxt;
      r_remaining  <= w_rem_nxt;
      r_abort_pend <= w_abort_nxt;
      r_start      <= w_start_nxt;
      r_address    <= w_address_nxt;
      r_selection  <= w_selection_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_stride_nxt    = r_stride;
    w_sel_nxt       = r_sel;
    w_rem_nxt       = r_remaining;
    w_abort_seen    = r_abort_pend | cfg_abort;
    w_abort_nxt     = w_abort_seen;
    w_start_nxt     = 1'b0;
    w_address_nxt   = r_address;
    w_selection_nxt = r_selection;
    w_done_nxt      = 1'b0;
    w_push          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_abort_nxt     = 1'b0;
        w_address_nxt   = '0;
        w_selection_nxt = '0;
        if (cfg_go) begin
          w_addr_nxt   = cfg_base;
          w_stride_nxt = cfg_stride;
          w_sel_nxt    = cfg_sel;
          w_rem_nxt    = cfg_count;
          if (cfg_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        w_address_nxt   = '0;
        w_selection_nxt = '0;
        if (w_abort_seen) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_level < DEPTH_L) begin
          // Issue only when the returned word is guaranteed a FIFO slot
          w_start_nxt     = 1'b1;
          w_address_nxt   = r_addr;
          w_selection_nxt = r_sel;
          w_state_nxt     = S_WAIT_ACT;
        end
      end

      S_WAIT_ACT: begin
        if (active) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (!active) begin
          w_push          = 1'b1;
          w_rem_nxt       = r_remaining - CW'(1);
          w_addr_nxt      = r_addr + r_stride;
          w_address_nxt   = '0;
          w_selection_nxt = '0;
          if ((w_rem_nxt == '0) || w_abort_seen) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign w_pop       = fifo_rd_en & ~r_empty;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
    end
  end

  // FIFO storage, no reset needed: reads are gated by r_empty
  always_ff @(posedge wb_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_rd;
    end
  end

  assign fifo_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_empty   = r_empty;
  assign fifo_level   = r_level;
  assign start        = r_start;
  assign address      = r_address;
  assign selection    = r_selection;
  assign busy         = r_busy;
  assign done         = r_done;
  assign write        = 1'b0;
  assign data_wr      = '0;

endmodule
